fir_share_scheduler: RTL and testbench
======================================

Name: fir_share_scheduler

Overview:
- Time-shares the single FIR filter datapath between NUM_REQ independent sample sources and one coefficient-configuration client.
- Accepts samples over valid/ready handshakes and grants requesters round-robin.
- Drives the filter's sample_data/data_ready inputs and tracks its modwait handshake.
- Returns each filtered result tagged with the originating requester ID; configuration requests get exclusive, prioritised access.

Parameters:
- NUM_REQ, 2, number of sample requesters (2..4); ID width IDW = 2 bits fixed.
- TIMEOUT, 16, max cycles to wait for modwait to rise after issue before aborting.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester sample valid
- req_data  in  16*NUM_REQ  per-requester sample; requester i occupies bits [16i+15:16i]
- req_ready  out  NUM_REQ  one-hot accept strobe
- cfg_req  in  1  coefficient-load client requests exclusive access; held until done
- cfg_gnt  out  1  exclusive access granted to coefficient client
- sample_data  out  16  sample to filter
- data_ready  out  1  sample-valid strobe to filter
- modwait  in  1  filter busy
- fir_out  in  16  filter result
- err  in  1  filter overflow error
- result_valid  out  1  one-cycle pulse: result fields valid
- result_data  out  16  captured fir_out
- result_id  out  2  requester index of result
- result_err  out  1  captured err, or timeout abort
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; state IDLE.
- Reset is asynchronous, so asserting rst mid-operation returns the block to IDLE immediately. No result is emitted for a sample that is in flight.
- State machine has states IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE and CFG.
- IDLE, priority 1: if cfg_req=1, go to CFG.
- IDLE, priority 2: else if any req_valid=1, select the first valid index at or after rr pointer, wrapping at NUM_REQ.
  - Pulse req_ready[sel] in that same cycle; the handshake completes when valid & ready.
  - Latch req_data[sel] into sample_data and sel into an ID register.
  - Set rr pointer = sel+1, modulo NUM_REQ.
  - Go to ISSUE.
- ISSUE: data_ready=1. Go to WAIT_HI.
- WAIT_HI: data_ready stays 1 and a timeout counter increments from 0.
  - On modwait=1: drop data_ready and go to WAIT_LO.
  - If the counter reaches TIMEOUT-1 with modwait still 0: drop data_ready, set result_err=1, result_data=0, go to DONE.
- WAIT_LO: wait for modwait=0, then capture fir_out into result_data and err into result_err. Go to DONE.
- DONE: result_valid=1 for exactly one cycle; result_id = latched ID. Go to IDLE.
- result_data, result_id and result_err hold their values until the next DONE.
- CFG: cfg_gnt=1 and data_ready=0. Exit to IDLE when cfg_req=0 and modwait=0; cfg_gnt drops on that transition.
- cfg_req is sampled only in IDLE. A request arriving mid-sample waits until the current sample reaches DONE and then wins over all pending samples.
- sample_data is stable from ISSUE through DONE and changes only on a new grant.
- req_ready is never asserted outside IDLE, and at most one bit is asserted per cycle.
- Minimum sample-to-result latency: 1 (IDLE) + 1 (ISSUE) + modwait high duration + 1 (WAIT_LO detect) + DONE cycle.

Test Plan:
- Single sample: req_valid[0]=1, req_data=16'h0040; filter model raises modwait 1 cycle after data_ready and holds it 4 cycles with fir_out=16'h1234 → one req_ready[0] pulse; data_ready high until modwait rises; result_valid pulse with result_data=16'h1234, result_id=0, result_err=0.
- Round-robin fairness: requesters 0 and 1 both hold valid for 4 samples → grant order 0,1,0,1; each result_id matches its grant; no requester is granted twice in a row while the other is valid.
- Config priority: cfg_req rises during WAIT_LO of a sample while req_valid[1]=1 → the sample completes with a result_valid pulse, then cfg_gnt=1 before req_ready[1]; cfg_gnt drops one cycle after cfg_req=0 with modwait=0; req_ready[1] follows.
- Timeout: modwait held 0 after issue → data_ready high exactly TIMEOUT cycles in WAIT_HI (16), then result_valid with result_err=1, result_data=0; next request is served normally.
- Filter error: model asserts err=1 while fir_out=16'h7FFF at modwait fall → result_err=1, result_data=16'h7FFF.
- Reset mid-operation: rst pulsed during WAIT_LO → all outputs 0 asynchronously; no result_valid after release; rr pointer 0, so requester 0 wins a simultaneous request.

Source files
------------

// File: rtl/fir_share_scheduler.sv
// rtl/fir_share_scheduler.sv - round-robin time-sharing of one FIR datapath with prioritised coefficient access
module fir_share_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [16*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic                   cfg_req,
   output logic                   cfg_gnt,
   output logic [15:0]            sample_data,
   output logic                   data_ready,
   input  logic                   modwait,
   input  logic [15:0]            fir_out,
   input  logic                   err,
   output logic                   result_valid,
   output logic [15:0]            result_data,
   output logic [1:0]             result_id,
   output logic                   result_err,
   output logic                   busy
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      DONE    = 3'd4,
      CFG     = 3'd5
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [1:0]           rr_ptr;
   logic [1:0]           id_reg;
   logic [CW-1:0]        wait_cnt;
   logic                 sel_found;
   logic [1:0]           sel_idx;
   logic [NUM_REQ-1:0]   sel_onehot;
   logic [15:0]          sel_data;
   logic [2:0]           cand;
   logic                 grant;
   logic                 timeout_hit;

   assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

   // Pick the first valid requester at or after the round-robin pointer, wrapping at NUM_REQ.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = 2'd0;
      sel_onehot = '0;
      sel_data   = 16'h0000;
      cand       = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + 3'(k);
         if (cand >= 3'(NUM_REQ)) begin
            cand = cand - 3'(NUM_REQ);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && (cand == 3'(i)) && req_valid[i]) begin
               sel_found     = 1'b1;
               sel_idx       = 2'(i);
               sel_onehot[i] = 1'b1;
               sel_data      = req_data[16*i +: 16];
            end
         end
      end
   end

   // Next-state and handshake decode; configuration wins over samples whenever IDLE sees it.
   always_comb begin
      state_next   = state;
      req_ready    = '0;
      data_ready   = 1'b0;
      cfg_gnt      = 1'b0;
      result_valid = 1'b0;
      grant        = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_req) begin
               state_next = CFG;
            end else if (sel_found && !rst) begin
               grant      = 1'b1;
               req_ready  = sel_onehot;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            data_ready = 1'b1;
            state_next = WAIT_HI;
         end
         WAIT_HI: begin
            data_ready = 1'b1;
            if (modwait) begin
               state_next = WAIT_LO;
            end else if (timeout_hit) begin
               state_next = DONE;
            end
         end
         WAIT_LO: begin
            if (!modwait) begin
               state_next = DONE;
            end
         end
         DONE: begin
            result_valid = 1'b1;
            state_next   = IDLE;
         end
         CFG: begin
            cfg_gnt = 1'b1;
            if (!cfg_req && !modwait) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Latch the granted sample and its ID, and advance the round-robin pointer past the winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_data <= 16'h0000;
         id_reg      <= 2'd0;
         rr_ptr      <= 2'd0;
      end else if (grant) begin
         sample_data <= sel_data;
         id_reg      <= sel_idx;
         rr_ptr      <= (sel_idx == 2'(NUM_REQ - 1)) ? 2'd0 : sel_idx + 2'd1;
      end
   end

   // Cycles spent in WAIT_HI waiting for the filter to acknowledge the sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == ISSUE) begin
         wait_cnt <= '0;
      end else if (state == WAIT_HI) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Result fields update only when heading into DONE and hold until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_data <= 16'h0000;
         result_err  <= 1'b0;
         result_id   <= 2'd0;
      end else if ((state == WAIT_HI) && !modwait && timeout_hit) begin
         result_data <= 16'h0000;
         result_err  <= 1'b1;
         result_id   <= id_reg;
      end else if ((state == WAIT_LO) && !modwait) begin
         result_data <= fir_out;
         result_err  <= err;
         result_id   <= id_reg;
      end
   end

endmodule

// File: tb/tb_fir_share_scheduler.sv
// tb/tb_fir_share_scheduler.sv - directed self-checking bench for fir_share_scheduler
module tb_fir_share_scheduler;

   localparam int NUM_REQ = 2;
   localparam int TIMEOUT = 16;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [16*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  cfg_req;
   logic                  cfg_gnt;
   logic [15:0]           sample_data;
   logic                  data_ready;
   logic                  modwait;
   logic [15:0]           fir_out;
   logic                  err;
   logic                  result_valid;
   logic [15:0]           result_data;
   logic [1:0]            result_id;
   logic                  result_err;
   logic                  busy;

   int vectors;
   int miscompares;
   int remaining [NUM_REQ];

   fir_share_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .cfg_req(cfg_req), .cfg_gnt(cfg_gnt),
      .sample_data(sample_data), .data_ready(data_ready),
      .modwait(modwait), .fir_out(fir_out), .err(err),
      .result_valid(result_valid), .result_data(result_data),
      .result_id(result_id), .result_err(result_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for a grant, then plays the filter: modwait rises the cycle after ISSUE and stays
   // high for 'hold' cycles (hold = 0 never raises it); returns what the DUT reported.
   task automatic do_sample(input int hold, input logic [15:0] res, input logic e, input logic cfg_mid,
                            output int gid, output logic [15:0] sd, output logic [15:0] rd,
                            output logic [1:0] rid, output logic rerr, output int dr);
      logic seen;
      gid = -1; sd = '0; rd = '0; rid = '0; rerr = 1'b0; dr = 0; seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            seen = 1'b1;
            gid  = req_ready[1] ? 1 : 0;
            chk("req_ready_onehot", 32'($countones(req_ready)), 32'd1);
         end else begin
            tick();
         end
      end
      chk("grant_seen", 32'(seen), 32'd1);
      if (!seen) return;
      tick();
      if (remaining[gid] > 0) remaining[gid]--;
      if (remaining[gid] == 0) req_valid[gid] = 1'b0;
      @(negedge clk);
      sd = sample_data;
      dr += int'(data_ready);
      tick();
      if (hold > 0) begin
         modwait = 1'b1;
         @(negedge clk);
         dr += int'(data_ready);
         for (int i = 1; i < hold; i++) begin
            tick();
            if (i == 1 && cfg_mid) cfg_req = 1'b1;
            @(negedge clk);
            dr += int'(data_ready);
         end
         tick();
         modwait = 1'b0;
         fir_out = res;
         err     = e;
      end
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (result_valid) begin
            seen = 1'b1;
            rd   = result_data;
            rid  = result_id;
            rerr = result_err;
         end else begin
            dr += int'(data_ready);
            tick();
         end
      end
      chk("result_seen", 32'(seen), 32'd1);
      tick();
   endtask

   initial begin
      int gid;
      int dr;
      logic [15:0] sd;
      logic [15:0] rd;
      logic [1:0]  rid;
      logic        rerr;
      logic        rv_seen;
      int          exp_gid [4];

      vectors = 0; miscompares = 0;
      for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
      rst = 1'b1; req_valid = '0; req_data = '0; cfg_req = 1'b0;
      modwait = 1'b0; fir_out = 16'h0000; err = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data_ready", 32'(data_ready), 32'd0);
      chk("rst_cfg_gnt", 32'(cfg_gnt), 32'd0);
      chk("rst_sample_data", 32'(sample_data), 32'd0);
      chk("rst_result", 32'({result_valid, result_err, result_id, result_data}), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Single sample from requester 0
      req_data[15:0] = 16'h0040; remaining[0] = 1; req_valid[0] = 1'b1;
      do_sample(4, 16'h1234, 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
      chk("single_gid", 32'(gid), 32'd0);
      chk("single_sample_data", 32'(sd), 32'h0040);
      chk("single_data_ready_cycles", 32'(dr), 32'd2);
      chk("single_result_data", 32'(rd), 32'h1234);
      chk("single_result_id", 32'(rid), 32'd0);
      chk("single_result_err", 32'(rerr), 32'd0);
      @(negedge clk);
      chk("hold_result_valid_low", 32'(result_valid), 32'd0);
      chk("hold_result_data", 32'(result_data), 32'h1234);
      tick();

      // Lone requester 1 sample (pointer now at 1, moves back to 0 afterwards)
      req_data[31:16] = 16'h0101; remaining[1] = 1; req_valid[1] = 1'b1;
      do_sample(2, 16'h0AAA, 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
      chk("r1_gid", 32'(gid), 32'd1);
      chk("r1_result_data", 32'(rd), 32'h0AAA);
      chk("r1_result_id", 32'(rid), 32'd1);

      // Round robin: both requesters valid for two samples each
      req_data = {16'h2000, 16'h1000};
      remaining[0] = 2; remaining[1] = 2; req_valid = 2'b11;
      exp_gid[0] = 0; exp_gid[1] = 1; exp_gid[2] = 0; exp_gid[3] = 1;
      for (int k = 0; k < 4; k++) begin
         do_sample(3, 16'h5000 + 16'(k), 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
         chk($sformatf("rr_gid_%0d", k), 32'(gid), 32'(exp_gid[k]));
         chk($sformatf("rr_sample_%0d", k), 32'(sd), (exp_gid[k] == 0) ? 32'h1000 : 32'h2000);
         chk($sformatf("rr_result_id_%0d", k), 32'(rid), 32'(exp_gid[k]));
         chk($sformatf("rr_result_data_%0d", k), 32'(rd), 32'h5000 + 32'(k));
      end

      // Config priority: cfg_req rises during WAIT_LO of requester 0 while requester 1 waits
      req_data = {16'h3333, 16'h0C0C};
      remaining[0] = 1; remaining[1] = 1; req_valid = 2'b11;
      do_sample(4, 16'h6666, 1'b0, 1'b1, gid, sd, rd, rid, rerr, dr);
      chk("cfg_sample_gid", 32'(gid), 32'd0);
      chk("cfg_sample_result", 32'(rd), 32'h6666);
      @(negedge clk);
      chk("cfg_idle_no_ready", 32'(req_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("cfg_gnt_high", 32'(cfg_gnt), 32'd1);
      chk("cfg_no_ready", 32'(req_ready), 32'd0);
      chk("cfg_data_ready_low", 32'(data_ready), 32'd0);
      tick();
      cfg_req = 1'b0; modwait = 1'b1;
      tick();
      @(negedge clk);
      chk("cfg_hold_on_modwait", 32'(cfg_gnt), 32'd1);
      tick();
      modwait = 1'b0;
      tick();
      @(negedge clk);
      chk("cfg_gnt_dropped", 32'(cfg_gnt), 32'd0);
      chk("cfg_then_ready1", 32'(req_ready), 32'b10);
      do_sample(2, 16'h7777, 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
      chk("cfg_after_gid", 32'(gid), 32'd1);
      chk("cfg_after_sample", 32'(sd), 32'h3333);

      // Timeout: modwait never rises
      req_data[15:0] = 16'h0777; remaining[0] = 1; req_valid[0] = 1'b1;
      do_sample(0, 16'h0000, 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
      chk("to_gid", 32'(gid), 32'd0);
      chk("to_data_ready_cycles", 32'(dr), 32'(TIMEOUT + 1));
      chk("to_result_err", 32'(rerr), 32'd1);
      chk("to_result_data", 32'(rd), 32'd0);
      req_data[31:16] = 16'h0999; remaining[1] = 1; req_valid[1] = 1'b1;
      do_sample(2, 16'h4444, 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
      chk("post_to_gid", 32'(gid), 32'd1);
      chk("post_to_result", 32'({rerr, rid, rd}), {13'd0, 1'b0, 2'd1, 16'h4444});

      // Filter overflow error
      req_data[15:0] = 16'h0111; remaining[0] = 1; req_valid[0] = 1'b1;
      do_sample(3, 16'h7FFF, 1'b1, 1'b0, gid, sd, rd, rid, rerr, dr);
      err = 1'b0;
      chk("ferr_result_err", 32'(rerr), 32'd1);
      chk("ferr_result_data", 32'(rd), 32'h7FFF);

      // Reset during WAIT_LO (pointer is at 1 before the reset)
      req_data[31:16] = 16'h5A5A; remaining[1] = 1; req_valid[1] = 1'b1;
      @(negedge clk);
      chk("mid_grant1", 32'(req_ready), 32'b10);
      tick();
      req_valid = '0; remaining[1] = 0;
      tick();
      modwait = 1'b1;
      tick();
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_sample_data", 32'(sample_data), 32'd0);
      chk("async_result", 32'({result_valid, result_err, result_id, result_data}), 32'd0);
      chk("async_ctrl", 32'({req_ready, cfg_gnt, data_ready}), 32'd0);
      modwait = 1'b0;
      tick();
      rst = 1'b0;
      rv_seen = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         rv_seen = rv_seen | result_valid | busy;
         tick();
      end
      chk("no_result_after_reset", 32'(rv_seen), 32'd0);
      req_data = {16'hBBBB, 16'hAAAA};
      remaining[0] = 1; remaining[1] = 1; req_valid = 2'b11;
      do_sample(2, 16'h0F0F, 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
      chk("post_rst_gid", 32'(gid), 32'd0);
      chk("post_rst_sample", 32'(sd), 32'hAAAA);
      do_sample(2, 16'h0E0E, 1'b0, 1'b0, gid, sd, rd, rid, rerr, dr);
      chk("post_rst_gid2", 32'(gid), 32'd1);
      chk("post_rst_result", 32'({rid, rd}), {14'd0, 2'd1, 16'h0E0E});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
